prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Serial program loader that sits directly upstream of the 32x8 instruction store.
//  Receives 8N1 UART bytes on rx and parses a length-prefixed frame: byte 0 = N, then N
//  program bytes. Each program byte is issued as a one-cycle WR pulse with data_out.
//  Holds the CPU (loading=1) until the load completes or fails.
// PARAMETERS
//  CLKS_PER_BIT  868  CPU_Clk cycles per UART bit (100 MHz / 115200); min 4
//  LENGTH        32   instruction store depth; max accepted N = LENGTH-1
// PORTS
//  CPU_Clk    in   1  clock, all logic on rising edge
//  Reset      in   1  asynchronous, active-high; clears all state
//  rx         in   1  UART serial input, idle high, async to CPU_Clk
//  full       in   1  store-full flag from instruction store
//  WR         out  1  one-cycle write strobe to store
//  data_out   out  8  program byte, valid when WR=1
//  loading    out  1  1 while waiting for/receiving a frame (CPU hold)
//  load_done  out  1  sticky: N bytes written successfully
//  load_err   out  1  sticky: bad length, framing error or store overflow
//  byte_cnt   out  6  program bytes written so far (0..LENGTH-1)
// BEHAVIOUR
//  Reset (async): WR=0, data_out=0, loading=1, load_done=0, load_err=0, byte_cnt=0;
//   both FSMs to idle; asserting Reset mid-frame aborts it, and no WR is issued afterwards.
//  rx passes a 2-flop synchroniser (reset value 1); all decisions use the synced bit.
//  RX FSM: R_IDLE -> R_START on synced falling edge; counter restarts.
//   R_START: at CLKS_PER_BIT/2, if rx=0 -> R_DATA, else glitch -> R_IDLE (no byte).
//   R_DATA: sample every CLKS_PER_BIT, 8 bits LSB first -> R_STOP.
//   R_STOP: sample after CLKS_PER_BIT; rx=1 -> byte_valid pulse (1 cycle);
//    rx=0 -> frame error pulse, byte discarded. Return to R_IDLE in both cases.
//  Loader FSM: L_LEN -> L_DATA -> L_DONE | L_ERR.
//   L_LEN: on byte_valid latch N; N==0 or N>LENGTH-1 -> L_ERR; else -> L_DATA with cnt=0.
//   L_DATA: on byte_valid, if full=0: WR=1 for exactly 1 cycle, data_out=byte, cnt+1.
//    If full=1 on byte_valid: no WR, -> L_ERR (overflow).
//    After the WR that makes cnt==N -> L_DONE (next cycle).
//   L_DONE: loading=0, load_done=1; further rx bytes ignored; exit only via Reset.
//   L_ERR: loading=0, load_err=1; no WR ever; exit only via Reset.
//   Frame error in L_LEN or L_DATA -> L_ERR.
//  Latency: WR asserts on the cycle after the stop-bit sample. At most one WR per byte.
//   WR is never asserted in two consecutive cycles.
//  data_out holds its last value between strobes. byte_cnt = cnt; it saturates at N.
// STRUCTURE
//  Shared package (cpu_pkg): UART state encodings, loader state encodings,
//   and localparam DATA_W=8.
//  One sub-module: uart_rx (synchroniser, bit counter, RX FSM; outputs byte, byte_valid,
//   frame_err). prog_loader instantiates uart_rx plus the loader FSM.
//  Counters sized with $clog2(CLKS_PER_BIT) and $clog2(LENGTH)+1.
// TESTING (CLKS_PER_BIT=4)
//  Send N=3, bytes 0xA1,0x5C,0xFF -> three WR pulses, data_out A1,5C,FF;
//   byte_cnt=3; load_done=1, loading=0.
//  Send N=0, and separately N=32 -> load_err=1, zero WR pulses, load_done=0.
//  Send N=2, byte 0x11 with stop bit=0 -> load_err=1, no WR for that byte.
//  rx low for 1 cycle only (glitch), then valid N=1, 0x7E -> single WR 0x7E, load_done=1.
//  Send N=4, tie full=1 before the 3rd byte -> 2 WR pulses, then load_err=1, byte_cnt=2.
//  Assert Reset mid-byte during L_DATA -> outputs at reset values immediately;
//   a fresh N=1, 0x42 frame loads correctly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared encodings for the program loader: UART receiver and loader FSM states.
package cpu_pkg;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE, L_ERR} ld_state_t;
endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte/error strobes.
module uart_rx
   import cpu_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              CPU_Clk,
   input  logic              Reset,
   input  logic              rx,
   output logic [DATA_W-1:0] rx_byte,
   output logic              byte_valid,
   output logic              frame_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   logic              sync1, rx_s, rx_prev;
   rx_state_t         state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [2:0]        bit_idx, bit_n;
   logic [DATA_W-1:0] shreg, sh_n;

   always_ff @(posedge CPU_Clk or posedge Reset) begin
      if (Reset) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
         state   <= R_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         sync1   <= rx;
         rx_s    <= sync1;
         rx_prev <= rx_s;
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shreg   <= sh_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      bit_n   = bit_idx;
      sh_n    = shreg;
      case (state)
         R_IDLE: begin
            cnt_n = '0;
            if (rx_prev && !rx_s) state_n = R_START;
         end
         R_START: if (cnt == HALF) begin
            // still low at mid start bit: genuine start, else a glitch
            cnt_n   = '0;
            bit_n   = '0;
            state_n = rx_s ? R_IDLE : R_DATA;
         end
         R_DATA: if (cnt == FULL) begin
            cnt_n = '0;
            sh_n  = {rx_s, shreg[DATA_W-1:1]};
            bit_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_n = R_STOP;
         end
         R_STOP: if (cnt == FULL) begin
            cnt_n   = '0;
            state_n = R_IDLE;
         end
         default: state_n = R_IDLE;
      endcase
   end

   // strobes fire on the stop-bit sample cycle so the loader registers WR one cycle later
   assign rx_byte    = shreg;
   assign byte_valid = (state == R_STOP) && (cnt == FULL) && rx_s;
   assign frame_err  = (state == R_STOP) && (cnt == FULL) && !rx_s;
endmodule

// File: rtl/prog_loader.sv
// Length-prefixed serial program loader feeding the instruction store; holds the CPU while loading.
module prog_loader
   import cpu_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int LENGTH       = 32
) (
   input  logic                        CPU_Clk,
   input  logic                        Reset,
   input  logic                        rx,
   input  logic                        full,
   output logic                        WR,
   output logic [DATA_W-1:0]           data_out,
   output logic                        loading,
   output logic                        load_done,
   output logic                        load_err,
   output logic [$clog2(LENGTH):0]     byte_cnt
);
   localparam int CNT_W = $clog2(LENGTH) + 1;
   localparam logic [DATA_W-1:0] MAX_N = DATA_W'(LENGTH - 1);

   logic [DATA_W-1:0] rx_byte;
   logic              byte_valid, frame_err;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .CPU_Clk    (CPU_Clk),
      .Reset      (Reset),
      .rx         (rx),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   ld_state_t         state, state_n;
   logic [CNT_W-1:0]  n_q, n_n, cnt, cnt_n;
   logic              wr_n;
   logic [DATA_W-1:0] dout_n;

   always_ff @(posedge CPU_Clk or posedge Reset) begin
      if (Reset) begin
         state    <= L_LEN;
         n_q      <= '0;
         cnt      <= '0;
         WR       <= 1'b0;
         data_out <= '0;
      end else begin
         state    <= state_n;
         n_q      <= n_n;
         cnt      <= cnt_n;
         WR       <= wr_n;
         data_out <= dout_n;
      end
   end

   always_comb begin
      state_n = state;
      n_n     = n_q;
      cnt_n   = cnt;
      wr_n    = 1'b0;
      dout_n  = data_out;
      case (state)
         L_LEN: begin
            if (frame_err) state_n = L_ERR;
            else if (byte_valid) begin
               if (rx_byte == '0 || rx_byte > MAX_N) state_n = L_ERR;
               else begin
                  n_n     = CNT_W'(rx_byte);
                  cnt_n   = '0;
                  state_n = L_DATA;
               end
            end
         end
         L_DATA: begin
            if (frame_err) state_n = L_ERR;
            else if (byte_valid) begin
               if (full) state_n = L_ERR;
               else begin
                  wr_n   = 1'b1;
                  dout_n = rx_byte;
                  cnt_n  = cnt + 1'b1;
                  if (cnt + 1'b1 == n_q) state_n = L_DONE;
               end
            end
         end
         default: ;
      endcase
   end

   assign loading   = (state == L_LEN) || (state == L_DATA);
   assign load_done = (state == L_DONE);
   assign load_err  = (state == L_ERR);
   assign byte_cnt  = cnt;
endmodule

// File: tb/tb_prog_loader.sv
// Directed + randomized frames against a byte-level reference model of the loader.
module tb_prog_loader;
   localparam int CPB = 4;
   localparam int LEN = 32;

   logic       CPU_Clk = 0;
   logic       Reset = 1;
   logic       rx = 1;
   logic       full = 0;
   logic       WR;
   logic [7:0] data_out;
   logic       loading, load_done, load_err;
   logic [5:0] byte_cnt;

   prog_loader #(.CLKS_PER_BIT(CPB), .LENGTH(LEN)) dut (
      .CPU_Clk   (CPU_Clk),
      .Reset     (Reset),
      .rx        (rx),
      .full      (full),
      .WR        (WR),
      .data_out  (data_out),
      .loading   (loading),
      .load_done (load_done),
      .load_err  (load_err),
      .byte_cnt  (byte_cnt)
   );

   always #5 CPU_Clk = ~CPU_Clk;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] wr_q[$];
   int         consec = 0;
   bit         wr_last = 0;

   always @(posedge CPU_Clk) begin
      #1;
      if (WR === 1'b1) begin
         wr_q.push_back(data_out);
         if (wr_last) consec++;
      end
      wr_last = (WR === 1'b1);
   end

   // frame under test
   logic [7:0] fb[0:47];
   bit         fs[0:47];
   int         flen;
   int         full_from;
   bit         glitch;

   logic [7:0] exp_q[$];
   bit         exp_done, exp_err;
   int         exp_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge CPU_Clk);
      Reset = 1; rx = 1; full = 0;
      repeat (3) @(negedge CPU_Clk);
      Reset = 0;
      repeat (3) @(negedge CPU_Clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop);
      rx = 0;
      repeat (CPB) @(negedge CPU_Clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge CPU_Clk);
      end
      rx = stop;
      repeat (CPB) @(negedge CPU_Clk);
      rx = 1;
      repeat (CPB) @(negedge CPU_Clk);
   endtask

   // Reference: walk the frame byte by byte applying the loader's rules.
   task automatic model();
      int n;
      exp_q.delete();
      exp_done = 0; exp_err = 0; exp_cnt = 0;
      if (!fs[0] || fb[0] == 0 || int'(fb[0]) > LEN - 1) exp_err = 1;
      else begin
         n = fb[0];
         for (int i = 1; i < flen; i++) begin
            if (exp_done || exp_err) break;
            if (!fs[i] || (i - 1) >= full_from) exp_err = 1;
            else begin
               exp_q.push_back(fb[i]);
               exp_cnt++;
               if (exp_cnt == n) exp_done = 1;
            end
         end
      end
   endtask

   task automatic run_frame(input string tag);
      do_reset();
      wr_q.delete();
      consec = 0;
      if (glitch) begin
         rx = 0;
         @(negedge CPU_Clk);
         rx = 1;
         repeat (3 * CPB) @(negedge CPU_Clk);
      end
      for (int i = 0; i < flen; i++) begin
         full = (i >= 1) && ((i - 1) >= full_from);
         send_byte(fb[i], fs[i]);
      end
      repeat (10) @(negedge CPU_Clk);
      model();
      check({tag, ".wr_count"}, wr_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
         check({tag, ".data"}, wr_q[i], exp_q[i]);
      check({tag, ".byte_cnt"}, byte_cnt, exp_cnt);
      check({tag, ".load_done"}, load_done, exp_done);
      check({tag, ".load_err"}, load_err, exp_err);
      check({tag, ".loading"}, loading, !(exp_done || exp_err));
      check({tag, ".consec_wr"}, consec, 0);
      glitch = 0;
      full_from = 99;
   endtask

   task automatic set_frame(input int len);
      flen = len;
      for (int i = 0; i < 48; i++) begin
         fb[i] = 8'h00;
         fs[i] = 1;
      end
   endtask

   initial begin
      glitch = 0;
      full_from = 99;
      repeat (2) @(negedge CPU_Clk);
      // reset state
      check("rst.WR", WR, 0);
      check("rst.data_out", data_out, 0);
      check("rst.loading", loading, 1);
      check("rst.load_done", load_done, 0);
      check("rst.load_err", load_err, 0);
      check("rst.byte_cnt", byte_cnt, 0);

      set_frame(4); fb[0] = 3; fb[1] = 8'hA1; fb[2] = 8'h5C; fb[3] = 8'hFF;
      run_frame("basic3");

      set_frame(1); fb[0] = 0;
      run_frame("n_zero");

      set_frame(1); fb[0] = 32;
      run_frame("n_32");

      set_frame(2); fb[0] = 2; fb[1] = 8'h11; fs[1] = 0;
      run_frame("stop_err");

      set_frame(2); fb[0] = 1; fb[1] = 8'h7E; glitch = 1;
      run_frame("glitch");

      set_frame(5); fb[0] = 4; fb[1] = 8'h01; fb[2] = 8'h02; fb[3] = 8'h03; fb[4] = 8'h04;
      full_from = 2;
      run_frame("full");

      set_frame(3); fb[0] = 31; fb[1] = 8'h33; fb[2] = 8'h44;
      run_frame("partial");

      // reset mid-byte while in L_DATA
      do_reset();
      send_byte(8'd3, 1);
      send_byte(8'hAA, 1);
      rx = 0;
      repeat (CPB * 3) @(negedge CPU_Clk);
      rx = 1;
      repeat (CPB) @(negedge CPU_Clk);
      #2 Reset = 1;
      #1;
      wr_q.delete();
      check("midrst.WR", WR, 0);
      check("midrst.data_out", data_out, 0);
      check("midrst.loading", loading, 1);
      check("midrst.load_done", load_done, 0);
      check("midrst.load_err", load_err, 0);
      check("midrst.byte_cnt", byte_cnt, 0);
      repeat (CPB * 12) @(negedge CPU_Clk);
      check("midrst.no_wr", wr_q.size(), 0);
      set_frame(2); fb[0] = 1; fb[1] = 8'h42;
      run_frame("after_rst");

      // randomized frames
      for (int k = 0; k < 8; k++) begin
         int n, mode;
         n = $urandom_range(1, 31);
         mode = $urandom_range(0, 3);
         set_frame(n + 1 + $urandom_range(0, 2));
         fb[0] = 8'(n);
         for (int i = 1; i < flen; i++) fb[i] = 8'($urandom);
         if (mode == 1) fs[$urandom_range(0, flen - 1)] = 0;
         if (mode == 2) full_from = $urandom_range(0, n - 1);
         if (mode == 3) fb[0] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(32, 255));
         run_frame($sformatf("rand%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
